// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
//   Receive-side controller for the UART receiver. Each completed byte
//   (rx_end/rx_data) is pushed into a small FIFO. The FIFO and the status,
//   control and clear registers are exposed through a four-register bus
//   slave. The block tracks overrun and idle-timeout conditions and raises
//   a level interrupt on FIFO fill level and error events.
//
// Ports
//   clk      in   1   clock
//   reset    in   1   synchronous, active-high reset
//   rx_end   in   1   one-cycle pulse: rx_data holds a good byte
//   rx_data  in   8   received byte, valid while rx_end=1
//   rx_busy  in   1   receiver is mid-frame (freezes the idle timer)
//   req      in   1   bus access strobe, held until ack
//   we       in   1   1=write, 0=read
//   addr     in   2   0 DATA, 1 STATUS, 2 CTRL, 3 CLEAR
//   wr_data  in   32  write data
//   rd_data  out  32  read data, valid with ack, otherwise 0
//   ack      out  1   access complete (one cycle)
//   irq      out  1   level interrupt
module uart_rx_ctrl #(
  parameter int          DEPTH   = 8,
  parameter int          CW      = 4,
  parameter logic [15:0] TIMEOUT = 16'd4340
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_end,
  input  logic [7:0]  rx_data,
  input  logic        rx_busy,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        ack,
  output logic        irq
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state;
  logic          we_q;
  logic [1:0]    addr_q;
  logic [31:0]   wdata_q;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          ovr;
  logic          tmo;
  logic [CW-1:0] thr;
  logic          ie_thr;
  logic          ie_ovr;
  logic          ie_tmo;
  logic [15:0]   tmo_cnt;
  logic          irq_q;

  logic          acc;
  logic          empty;
  logic          full;
  logic          pop;
  logic          flush;
  logic          push_ok;
  logic          ovr_set;
  logic          ovr_clr;
  logic          tmo_clr;
  logic          tmo_load;
  logic          tmo_step;
  logic          tmo_set;
  logic [15:0]   tmo_inc;
  logic          ctrl_wr;
  logic [31:0]   rd_mux;
  logic          unused_wdata;

  // Access decode: everything a bus access does happens in the ACK cycle,
  // using the request fields latched on entry.
  assign acc     = (state == ACK);
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop     = acc && !we_q && (addr_q == 2'd0) && !empty;
  assign ctrl_wr = acc && we_q && (addr_q == 2'd2);
  assign flush   = ctrl_wr && wdata_q[16];
  assign ovr_clr = acc && we_q && (addr_q == 2'd3) && wdata_q[10];
  assign tmo_clr = acc && we_q && (addr_q == 2'd3) && wdata_q[11];

  // A flush discards any byte arriving in the same cycle. When full, a byte
  // still fits if the head is leaving in the same cycle.
  assign push_ok = rx_end && !flush && (!full || pop);
  assign ovr_set = rx_end && !flush && full && !pop;

  // Idle timer: tmo sets only on the step that lands on TIMEOUT, so a
  // cleared tmo stays clear while the counter sits at its ceiling.
  assign tmo_load = rx_end || pop || flush || empty;
  assign tmo_step = !tmo_load && !rx_busy && (tmo_cnt != TIMEOUT);
  assign tmo_inc  = tmo_cnt + 16'd1;
  assign tmo_set  = tmo_step && (tmo_inc == TIMEOUT);

  assign unused_wdata = ^{wdata_q[31:17], wdata_q[15:12], wdata_q[7:CW]};

  // Read mux; reflects state before this cycle's push or pop
  always_comb begin
    rd_mux = '0;
    if (acc && !we_q) begin
      case (addr_q)
        2'd0: if (!empty) rd_mux[7:0] = mem[rd_ptr];
        2'd1: begin
          rd_mux[CW-1:0] = count;
          rd_mux[8]      = empty;
          rd_mux[9]      = full;
          rd_mux[10]     = ovr;
          rd_mux[11]     = tmo;
        end
        2'd2: begin
          rd_mux[CW-1:0] = thr;
          rd_mux[8]      = ie_thr;
          rd_mux[9]      = ie_ovr;
          rd_mux[10]     = ie_tmo;
        end
        default: rd_mux = '0;
      endcase
    end
  end

  assign rd_data = rd_mux;
  assign ack     = acc;
  assign irq     = irq_q;

  // Bus FSM and latched request
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (req) state <= ACK;
        ACK:     state <= WAIT;
        WAIT:    if (!req) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wr_data;
    end
  end

  // FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  // FIFO pointers and count
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Control register, sticky flags, idle timer
  always_ff @(posedge clk) begin
    if (reset) begin
      thr     <= CW'(1);
      ie_thr  <= 1'b0;
      ie_ovr  <= 1'b0;
      ie_tmo  <= 1'b0;
      ovr     <= 1'b0;
      tmo     <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (ctrl_wr) begin
        thr    <= wdata_q[CW-1:0];
        ie_thr <= wdata_q[8];
        ie_ovr <= wdata_q[9];
        ie_tmo <= wdata_q[10];
      end
      // set wins over a simultaneous clear
      ovr <= ovr_set || (ovr && !ovr_clr);
      tmo <= tmo_set || (tmo && !tmo_clr);
      if (tmo_load)      tmo_cnt <= '0;
      else if (tmo_step) tmo_cnt <= tmo_inc;
    end
  end

  // Registered interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= (ie_thr && (count >= thr) && (thr != '0)) ||
               (ie_ovr && ovr) || (ie_tmo && tmo);
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
//   Directed bench for uart_rx_ctrl: FIFO ordering, overrun, simultaneous
//   push/pop when full, threshold and timeout interrupts, flush, and reset
//   during a bus access. Expected values are hand-computed constants.
module tb_uart_rx_ctrl;

  localparam int          DEPTH = 8;
  localparam int          CW    = 4;
  localparam int          T     = 4340;

  logic        clk;
  logic        reset;
  logic        rx_end;
  logic [7:0]  rx_data;
  logic        rx_busy;
  logic        req;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        ack;
  logic        irq;

  int n_tests;
  int n_fail;

  uart_rx_ctrl #(
    .DEPTH   (DEPTH),
    .CW      (CW),
    .TIMEOUT (16'(T))
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rx_end  (rx_end),
    .rx_data (rx_data),
    .rx_busy (rx_busy),
    .req     (req),
    .we      (we),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .ack     (ack),
    .irq     (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    rx_end  = 1'b1;
    rx_data = b;
    tick();
    rx_end  = 1'b0;
  endtask

  // One full bus access. Optionally pulses rx_end during the ACK cycle.
  task automatic bus(input logic w, input logic [1:0] a, input logic [31:0] wd,
                     input logic dp, input logic [7:0] pb, output logic [31:0] rd);
    int n;
    req = 1'b1; we = w; addr = a; wr_data = wd;
    n = 0;
    do begin
      tick();
      n++;
    end while (!ack && n < 4);
    chk("bus_ack", 32'(ack), 32'd1);
    rd = rd_data;
    if (dp) begin
      rx_end  = 1'b1;
      rx_data = pb;
    end
    tick();
    rx_end = 1'b0;
    req    = 1'b0;
    tick();
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] rd);
    bus(1'b0, a, 32'd0, 1'b0, 8'h00, rd);
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] dummy;
    bus(1'b1, a, wd, 1'b0, 8'h00, dummy);
  endtask

  logic [31:0] r;
  logic [7:0]  exp_b [8];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1; rx_end = 1'b0; rx_data = 8'h00; rx_busy = 1'b0;
    req = 1'b0; we = 1'b0; addr = 2'd0; wr_data = 32'd0;
    tick(); tick();
    reset = 1'b0;
    tick();

    // reset state
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rd_reg(2'd1, r); chk("rst_status", r, 32'h100);
    rd_reg(2'd2, r); chk("rst_ctrl", r, 32'h001);
    rd_reg(2'd3, r); chk("clear_reads0", r, 32'h0);

    // basic ordering
    push(8'h41); push(8'h42); push(8'h43);
    rd_reg(2'd1, r); chk("st_count3", r, 32'h003);
    rd_reg(2'd0, r); chk("data_41", r, 32'h41);
    rd_reg(2'd0, r); chk("data_42", r, 32'h42);
    rd_reg(2'd0, r); chk("data_43", r, 32'h43);
    rd_reg(2'd0, r); chk("data_empty", r, 32'h0);
    rd_reg(2'd1, r); chk("st_empty", r, 32'h100);

    // overrun: 9 pushes into 8 entries
    for (int i = 0; i < 9; i++) push(8'(8'h10 + i));
    rd_reg(2'd1, r); chk("st_ovr_full", r, 32'h608);
    wr_reg(2'd2, 32'h201);
    chk("irq_ovr", 32'(irq), 32'd1);
    wr_reg(2'd3, 32'h400);
    chk("irq_ovr_clr", 32'(irq), 32'd0);
    rd_reg(2'd1, r); chk("st_ovr_cleared", r, 32'h208);

    // full FIFO: pop and push in the same ACK cycle
    bus(1'b0, 2'd0, 32'd0, 1'b1, 8'h5A, r); chk("full_pp_data", r, 32'h10);
    rd_reg(2'd1, r); chk("full_pp_status", r, 32'h208);
    exp_b = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      rd_reg(2'd0, r);
      chk($sformatf("drain_%0d", i), r, 32'(exp_b[i]));
    end
    rd_reg(2'd1, r); chk("drain_status", r, 32'h100);

    // threshold interrupt
    wr_reg(2'd2, 32'h104);
    push(8'h31); push(8'h32); push(8'h33);
    tick(); tick();
    chk("thr_below", 32'(irq), 32'd0);
    push(8'h34);
    chk("thr_lat1", 32'(irq), 32'd0);
    tick();
    chk("thr_lat2", 32'(irq), 32'd1);
    rd_reg(2'd0, r); chk("thr_pop_data", r, 32'h31);
    chk("thr_irq_fall", 32'(irq), 32'd0);
    rd_reg(2'd0, r); rd_reg(2'd0, r); rd_reg(2'd0, r);
    chk("thr_last", r, 32'h34);

    // idle timeout
    wr_reg(2'd2, 32'h400);
    push(8'hA1);
    for (int i = 0; i < T; i++) tick();
    chk("tmo_early", 32'(irq), 32'd0);
    tick();
    chk("tmo_irq", 32'(irq), 32'd1);
    rd_reg(2'd1, r); chk("tmo_status", r, 32'h801);
    wr_reg(2'd3, 32'h800);
    chk("tmo_clr_irq", 32'(irq), 32'd0);
    rd_reg(2'd0, r); chk("tmo_data", r, 32'hA1);

    // timeout restarted by a second byte at TIMEOUT-5
    push(8'hB1);
    for (int i = 0; i < T - 6; i++) tick();
    push(8'hB2);
    for (int i = 0; i < 6; i++) tick();
    chk("tmo_restart_old", 32'(irq), 32'd0);
    for (int i = 0; i < T - 6; i++) tick();
    chk("tmo_restart_early", 32'(irq), 32'd0);
    tick();
    chk("tmo_restart_irq", 32'(irq), 32'd1);

    // fill to overrun, then flush with a coinciding push
    for (int i = 0; i < 7; i++) push(8'(8'hC0 + i));
    rd_reg(2'd1, r); chk("pre_flush_status", r, 32'hE08);
    bus(1'b1, 2'd2, 32'h10000, 1'b1, 8'hEE, r);
    rd_reg(2'd1, r); chk("flush_status", r, 32'hD00);
    rd_reg(2'd2, r); chk("flush_ctrl", r, 32'h000);
    chk("flush_irq", 32'(irq), 32'd0);
    push(8'h99);
    rd_reg(2'd0, r); chk("post_flush_data", r, 32'h99);

    // reset during WAIT with req still held
    req = 1'b1; we = 1'b0; addr = 2'd1; wr_data = 32'd0;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("rst_wait_ack", 32'(ack), 32'd0);
    reset = 1'b0;
    tick();
    chk("rst_wait_idle", 32'(ack), 32'd1);
    chk("rst_wait_status", rd_data, 32'h100);
    req = 1'b0;
    tick(); tick();
    rd_reg(2'd2, r); chk("rst_wait_ctrl", r, 32'h001);
    chk("rst_wait_irq", 32'(irq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
